// File: rtl/hls_axis_block_detector.sv
// Per-channel AXI-Stream stall detector feeding the HLS deadlock monitors.
// Flags a channel after THRESH consecutive stall cycles and latches the first channel to block.
module hls_axis_block_detector #(
  parameter int NUM_CH = 2,
  parameter int THRESH = 16,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_dir,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_idx
);

  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);

  logic [NUM_CH-1:0] stall_p0;
  logic [NUM_CH-1:0] blk_p0;
  logic [IDX_W-1:0]  first_p0;
  logic [CNT_W-1:0]  cnt_p1 [NUM_CH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c < THR) ? c + 1'b1 : c;
  endfunction

  // Stage p0: stall classification, next-state flags, lowest-index pick
  assign stall_p0 = (ch_dir & ch_valid & ~ch_ready) | (~ch_dir & ch_ready & ~ch_valid);

  always_comb begin
    blk_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      blk_p0[i] = en & stall_p0[i] & (cnt_p1[i] >= THR_M1);
    end
  end

  always_comb begin
    first_p0 = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (blk_p0[i]) first_p0 = IDX_W'(i);
    end
  end

  // Stage p1: saturating stall counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en || !stall_p0[i]) cnt_p1[i] <= '0;
        else                     cnt_p1[i] <= sat_inc(cnt_p1[i]);
      end
    end
  end

  // Stage p1: registered flags and first-block latch (clear beats capture)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      axis_block_sigs <= '0;
      any_block       <= 1'b0;
      first_valid     <= 1'b0;
      first_idx       <= '0;
    end else begin
      axis_block_sigs <= blk_p0;
      any_block       <= |blk_p0;
      if (clear) begin
        first_valid <= 1'b0;
        first_idx   <= '0;
      end else if (!first_valid && (|blk_p0)) begin
        first_valid <= 1'b1;
        first_idx   <= first_p0;
      end
    end
  end

endmodule

// File: tb/tb_hls_axis_block_detector.sv
// Bench for hls_axis_block_detector: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a run-length reference model.
module tb_hls_axis_block_detector;

  localparam int NUM_CH = 2;
  localparam int THRESH = 16;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 4;

  logic              clock;
  logic              reset;
  logic              en;
  logic              clear;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_dir;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_valid;
  logic [IDX_W-1:0]  first_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state: length of the current enabled stall run per channel
  int                run [NUM_CH];
  logic [NUM_CH-1:0] m_blk = '0;
  logic              m_any = 1'b0;
  logic              m_fv  = 1'b0;
  logic [IDX_W-1:0]  m_idx = '0;

  hls_axis_block_detector #(
    .NUM_CH(NUM_CH), .THRESH(THRESH), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .en(en),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_dir(ch_dir),
    .clear(clear),
    .axis_block_sigs(axis_block_sigs), .any_block(any_block),
    .first_valid(first_valid), .first_idx(first_idx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [NUM_CH-1:0] blk,
                            input logic fv, input logic [IDX_W-1:0] idx);
    check({name, "_blk"}, 32'(axis_block_sigs), 32'(blk));
    check({name, "_any"}, 32'(any_block), 32'(|blk));
    check({name, "_fv"},  32'(first_valid), 32'(fv));
    check({name, "_idx"}, 32'(first_idx), 32'(idx));
  endtask

  // Model: a channel is blocked once its consecutive enabled stall run reaches THRESH
  initial begin
    for (int i = 0; i < NUM_CH; i++) run[i] = 0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < NUM_CH; i++) run[i] = 0;
        m_blk = '0;
        m_any = 1'b0;
        m_fv  = 1'b0;
        m_idx = '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          bit st;
          st = ch_dir[i] ? (ch_valid[i] && !ch_ready[i]) : (ch_ready[i] && !ch_valid[i]);
          run[i] = (en && st) ? run[i] + 1 : 0;
          m_blk[i] = (run[i] >= THRESH);
        end
        m_any = |m_blk;
        if (clear) begin
          m_fv  = 1'b0;
          m_idx = '0;
        end else if (!m_fv && m_any) begin
          m_fv = 1'b1;
          for (int i = NUM_CH - 1; i >= 0; i--) if (m_blk[i]) m_idx = IDX_W'(i);
        end
      end
    end
  end

  // Every-cycle compare against the model, on the falling edge
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      check("cyc_blk", 32'(axis_block_sigs), 32'(m_blk));
      check("cyc_any", 32'(any_block), 32'(m_any));
      check("cyc_fv",  32'(first_valid), 32'(m_fv));
      check("cyc_idx", 32'(first_idx), 32'(m_idx));
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; clear = 1'b0;
    ch_valid = '0; ch_ready = '0; ch_dir = '0;
    tick(3);
    reset = 1'b0; en = 1'b1;

    // Idle: nothing may flag
    tick(50);
    expect_out("idle", 2'b00, 1'b0, 4'd0);

    // Output stream full-blocked on ch0
    ch_dir = 2'b01; ch_valid = 2'b01; ch_ready = 2'b00;
    tick(15);
    expect_out("full15", 2'b00, 1'b0, 4'd0);
    tick(1);
    expect_out("full16", 2'b01, 1'b1, 4'd0);
    check("model_full16", 32'(m_blk), 32'h1);
    ch_ready = 2'b01;
    tick(1);
    expect_out("full_unblk", 2'b00, 1'b1, 4'd0);

    // Input stream empty-blocked on ch1, broken by one handshake
    ch_valid = 2'b00; ch_ready = 2'b10;
    tick(10);
    expect_out("empty10", 2'b00, 1'b1, 4'd0);
    ch_valid = 2'b10;
    tick(1);
    ch_valid = 2'b00;
    tick(15);
    expect_out("empty_re15", 2'b00, 1'b1, 4'd0);
    tick(1);
    expect_out("empty_re16", 2'b10, 1'b1, 4'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("clr_wins", 2'b10, 1'b0, 4'd0);
    tick(1);
    expect_out("recap1", 2'b10, 1'b1, 4'd1);

    // Both channels start stalling together
    ch_valid = 2'b00; ch_ready = 2'b00; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    expect_out("quiet", 2'b00, 1'b0, 4'd0);
    ch_valid = 2'b01; ch_ready = 2'b10;
    tick(15);
    expect_out("sim15", 2'b00, 1'b0, 4'd0);
    tick(1);
    expect_out("sim16", 2'b11, 1'b1, 4'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("sim_clr", 2'b11, 1'b0, 4'd0);
    tick(1);
    expect_out("sim_recap", 2'b11, 1'b1, 4'd0);

    // Long stall: counter saturates, flag holds
    tick(300);
    expect_out("sat", 2'b11, 1'b1, 4'd0);
    check("sat_cnt", 32'(dut.cnt_p1[0]), 32'(THRESH));

    // Enable dropped mid-stall
    en = 1'b0;
    tick(1);
    expect_out("en_off", 2'b00, 1'b1, 4'd0);
    en = 1'b1;
    tick(15);
    expect_out("en_re15", 2'b00, 1'b1, 4'd0);
    tick(1);
    expect_out("en_re16", 2'b11, 1'b1, 4'd0);

    // Asynchronous reset between edges
    reset = 1'b1;
    #1;
    expect_out("async_rst", 2'b00, 1'b0, 4'd0);
    tick(2);
    reset = 1'b0;
    tick(15);
    expect_out("rst_re15", 2'b00, 1'b0, 4'd0);
    tick(1);
    expect_out("rst_re16", 2'b11, 1'b1, 4'd0);

    // Randomized traffic with persistent valid/ready levels
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(7) == 0) begin
          ch_valid[i] = 1'($urandom_range(1));
          ch_ready[i] = 1'($urandom_range(1));
        end
      end
      if ($urandom_range(63) == 0) ch_dir = 2'($urandom_range(3));
      en    = ($urandom_range(63) != 0);
      clear = ($urandom_range(39) == 0);
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      tick(1);
    end

    clear = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls_axis_block_detector.md
Name: hls_axis_block_detector

Overview:
- Generates the per-channel `axis_block_sigs` vector consumed by the HLS deadlock monitors.
- Watches AXI-Stream valid/ready pairs at the boundaries of an HLS instance.
- Flags a channel as blocked once it has stalled for a programmable number of consecutive cycles.
- Latches the first channel to block, for debug readout.

Parameters:
- NUM_CH, 2, number of monitored AXI-Stream channels (1..16).
- THRESH, 16, consecutive stall cycles before a channel is flagged blocked (1..2^CNT_W-1).
- CNT_W, 8, width of each per-channel stall counter.
- IDX_W, 4, width of the first-block index output (must satisfy 2^IDX_W >= NUM_CH).

Ports:
- clock  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  detection enable; 0 holds all counters and block flags at 0.
- ch_valid  input  NUM_CH  TVALID of each monitored stream.
- ch_ready  input  NUM_CH  TREADY of each monitored stream.
- ch_dir  input  NUM_CH  per channel: 1 = output stream of the instance, 0 = input stream of the instance.
- clear  input  1  synchronous pulse; clears the first-block latch.
- axis_block_sigs  output  NUM_CH  per-channel registered blocked flag.
- any_block  output  1  registered OR of axis_block_sigs.
- first_valid  output  1  a first-block event has been captured.
- first_idx  output  IDX_W  index of the first channel to block.

Behaviour:
- Reset (async, active-high): all counters, axis_block_sigs, any_block, first_valid and first_idx go to 0 immediately and stay 0 while reset is high.
- Stall condition per channel i:
  - ch_dir[i]=1: stall = ch_valid[i] & ~ch_ready[i] (instance output stream is full-blocked).
  - ch_dir[i]=0: stall = ch_ready[i] & ~ch_valid[i] (instance input stream is empty-blocked).
  - A cycle with ch_valid & ch_ready (handshake) is never a stall.
  - Valid=0 and ready=0 together is not a stall in either direction.
- Counter i, evaluated each rising edge:
  - en=0: cnt <= 0.
  - stall=0: cnt <= 0.
  - stall=1 and cnt < THRESH: cnt <= cnt+1.
  - stall=1 and cnt = THRESH: hold, saturating; no wrap.
- Block flag i, registered:
  - axis_block_sigs[i] <= en & stall & (cnt >= THRESH-1).
  - It therefore rises at the edge that completes the THRESH-th consecutive stall cycle.
  - It falls at the first edge where stall=0 or en=0, i.e. one cycle of latency after the stall clears.
  - THRESH=1: the flag rises one edge after the first stall cycle.
- any_block: registered in the same edge as the flags, computed from the next-state flags, so it is cycle-aligned with axis_block_sigs.
- First-block latch:
  - When first_valid=0 and any next-state flag is 1, set first_valid <= 1 and first_idx <= lowest index among the channels rising at that edge.
  - Once set, it holds through later block and unblock activity until clear.
  - clear=1 at an edge: first_valid <= 0 and first_idx <= 0. Counters and flags are unaffected.
  - clear=1 coincident with a new first-block condition: clear wins. The latch re-captures on the next edge if the flag is still asserted, because capture uses the flag-level next state.
- Simultaneous events: several channels reaching threshold on the same edge produce all their flags together; first_idx takes the lowest index.
- en deasserted mid-stall:
  - Counters and flags clear at the next edge.
  - The first-block latch is not cleared by en.
  - On re-enable, counting restarts from 0.
- Reset asserted mid-operation: everything returns to the reset state asynchronously, and counting restarts from 0 after reset deasserts.
- All outputs are registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/idle: reset high 3 cycles, then en=1, all valid/ready=0 for 50 cycles -> all outputs remain 0.
- Full-block threshold: NUM_CH=2, THRESH=16, ch_dir=2'b01, ch0 valid=1 ready=0 from cycle 0 -> axis_block_sigs=2'b01, any_block=1, first_valid=1, first_idx=0 at edge 16 (not 15). Then ready=1 for 1 cycle -> flag 0 at the next edge; latch still 1 with idx 0.
- Empty-block with interruption: ch1 dir=0, ready=1 valid=0 for 10 cycles, one handshake cycle, then 16 more stall cycles -> no flag during the first run; flag rises exactly 16 edges after the handshake cycle.
- Simultaneous and latch priority: both channels begin stalling on the same cycle -> both flags rise together and first_idx=0. Then clear pulse while both are still blocked -> first_valid=0 for 1 cycle, then recaptures idx 0.
- Saturation/long stall: stall 300 cycles with CNT_W=8 -> flag stays 1 continuously, no glitch at 255/256, and the counter never wraps.
- Async reset and en mid-stall:
  - Drop en at cycle 20 of a blocked stall -> flag 0 next edge; re-enable -> 16 more cycles required.
  - Assert reset between clock edges -> all outputs 0 before the next edge.
